// File: rtl/fop_seq.sv
`default_nettype none
// ============================================================================
// Module   : fop_seq
// Brief    : Start/stop run sequencer driving fop's reset and enable inputs.
//            Optional macro FOP_SEQ_AUTORESTART_EN repeats runs back to back.
// Revision : 1.0 - initial release
// ============================================================================
module fop_seq #(
    parameter int unsigned RESET_CYCLES = 1,
    parameter int unsigned RUN_CYCLES   = 10,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    output logic             fop_reset,
    output logic             fop_enable,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] run_count
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RESET = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_SAT      = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_RUN_LAST = CNT_W'(RUN_CYCLES - 1);
    localparam logic             c_RUN_FREE = (RUN_CYCLES == 0);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_clr_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_run_count;
    logic             r_fop_reset;
    logic             r_fop_enable;
    logic             r_busy;
    logic             r_done;
    logic             w_fop_reset;
    logic             w_fop_enable;
    logic             w_busy;
    logic             w_done;

    // State register; outputs are registered copies of the current-state decode,
    // so every output lags the state by exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_run_count  <= '0;
            r_fop_reset  <= 1'b0;
            r_fop_enable <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fop_reset  <= w_fop_reset;
            r_fop_enable <= w_fop_enable;
            r_busy       <= w_busy;
            r_done       <= w_done;

            if (w_clr_cnt) begin
                r_cnt <= '0;
            end else if (r_state == c_ST_RESET) begin
                r_cnt <= r_cnt + c_ONE;
            end

            // Clearing during RESET keeps the previous count visible while done is high.
            if (w_clr_cnt || (r_state == c_ST_RESET)) begin
                r_run_count <= '0;
            end else if ((r_state == c_ST_RUN) && (r_run_count != c_SAT)) begin
                r_run_count <= r_run_count + c_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_cnt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = c_ST_RESET;
                    w_clr_cnt   = 1'b1;
                end
            end
            c_ST_RESET: begin
                if (stop) begin
                    w_state_nxt = c_ST_DONE;
                end else if (r_cnt == c_RST_LAST) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (stop || (!c_RUN_FREE && (r_run_count == c_RUN_LAST))) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
`ifdef FOP_SEQ_AUTORESTART_EN
                if (stop) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_state_nxt = c_ST_RESET;
                    w_clr_cnt   = 1'b1;
                end
`else
                w_state_nxt = c_ST_IDLE;
`endif
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_fop_reset  = (r_state == c_ST_RESET);
        w_fop_enable = (r_state == c_ST_RUN);
        w_done       = (r_state == c_ST_DONE);
`ifdef FOP_SEQ_AUTORESTART_EN
        w_busy       = (r_state != c_ST_IDLE);
`else
        w_busy       = (r_state == c_ST_RESET) || (r_state == c_ST_RUN);
`endif
    end

    assign fop_reset  = r_fop_reset;
    assign fop_enable = r_fop_enable;
    assign busy       = r_busy;
    assign done       = r_done;
    assign run_count  = r_run_count;

endmodule
`default_nettype wire

// File: doc/fop_seq.md
# fop_seq

Run sequencer directly upstream of `fop`: drives `fop`'s `reset` and `enable` inputs from a start/stop command interface. On each start it applies a programmable-length reset pulse to `fop` and then holds `fop` enabled for a programmable number of cycles or until stopped. It then reports completion and the number of enabled cycles. This replaces hand-timed reset/enable stimulus with a reusable, synthesizable stage.

## Interface
- `RESET_CYCLES`, default 1: cycles `fop_reset` is held high per run; legal range 1..2^CNT_W-1.
- `RUN_CYCLES`, default 10: cycles `fop_enable` is held high per run; 0 means run until `stop`.
- `CNT_W`, default 16: width of the internal counters and of `run_count`.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset of this block.
- `start`  in  1  request a run; sampled only in IDLE.
- `stop`  in  1  abort or end the current run; sampled in RESET and RUN.
- `fop_reset`  out  1  to `fop.reset`; registered.
- `fop_enable`  out  1  to `fop.enable`; registered.
- `busy`  out  1  high in RESET and RUN.
- `done`  out  1  single-cycle pulse at the end of every run, including aborted runs.
- `run_count`  out  CNT_W  number of cycles `fop_enable` was high in the last run; held until the next start.

## Operation
- Reset values: state=IDLE; `fop_reset`=0, `fop_enable`=0, `busy`=0, `done`=0, `run_count`=0, counters=0.
- IDLE:
  - `start`=1 and `stop`=0 -> RESET. Clear the counter and `run_count`.
  - `start`=1 and `stop`=1 -> stay in IDLE; no run.
- RESET: `fop_reset`=1, `busy`=1.
  - The counter increments each cycle.
  - After RESET_CYCLES cycles, go to RUN.
  - `stop`=1 -> DONE next cycle; `fop_enable` never asserts.
- RUN: `fop_enable`=1, `busy`=1, `fop_reset`=0.
  - `run_count` increments each cycle, saturating at 2^CNT_W-1.
  - With RUN_CYCLES≠0, leave after RUN_CYCLES cycles.
  - `stop`=1 -> leave at the end of the current cycle. That cycle is counted.
  - Leaving RUN goes to DONE.
- DONE: one cycle; `done`=1, all other control outputs 0.
  - Next state is IDLE, or RESET if auto-restart is compiled in (see Configuration).
- `start` outside IDLE is ignored. `stop` in IDLE/DONE is ignored.
- `reset` asserted mid-run returns to IDLE asynchronously and drops `fop_enable`/`fop_reset` immediately. `done` does not pulse.

## Timing
- `start` high at edge N -> `fop_reset`=1 from edge N+1 through edge N+RESET_CYCLES.
- `fop_reset` falls and `fop_enable` rises on the same edge, N+RESET_CYCLES+1. There is no gap and no overlap.
- `fop_enable` stays high for exactly RUN_CYCLES cycles; `done` is high in the following cycle.
- Minimum IDLE-to-IDLE run length: RESET_CYCLES + RUN_CYCLES + 2 cycles.
- `stop` high at edge M during RUN -> `fop_enable` low from edge M+1; `done` high in cycle M+1.
- `run_count` updates on the same edge as each enabled cycle; it is final when `done` is high.

## Configuration
- `FOP_SEQ_AUTORESTART_EN` defined:
  - DONE goes to RESET, not IDLE, so runs repeat back to back.
  - `busy` stays high through DONE.
  - `stop` sampled high in DONE returns to IDLE and ends the loop.
- `FOP_SEQ_AUTORESTART_EN` undefined: DONE always goes to IDLE; no auto-restart logic is present.

## Test plan
- Defaults, pulse `start` 1 cycle -> `fop_reset` high 1 cycle, then `fop_enable` high 10 cycles, `done` 1 cycle, `run_count`=10, `busy` low afterwards.
- RESET_CYCLES=3, RUN_CYCLES=0, `stop` pulsed 5 cycles after `fop_enable` rises -> `fop_reset` high 3 cycles, `fop_enable` high 6 cycles, `run_count`=6, `done` pulses.
- `stop` high during RESET -> `fop_enable` never asserts, `done` pulses, `run_count`=0.
- `start` and `stop` high together in IDLE -> no output activity; `start` pulsed while busy -> exactly one run.
- Async `reset` asserted mid-RUN between clock edges -> `fop_enable` low immediately, no `done`, state IDLE, `run_count`=0.
- With `FOP_SEQ_AUTORESTART_EN`, defaults, single `start` -> three consecutive runs of 1 reset + 10 enable cycles each. `stop` high in the third DONE cycle -> returns to IDLE.
